// File: rtl/frontend_pkg.sv
// Shared frontend definitions: fetch-queue entry layout and default geometry.
// IFU, fetch_instr_queue and decoder_stage all size themselves from these.
package frontend_pkg;

   localparam int FQ_FETCH_WIDTH  = 4;
   localparam int FQ_DECODE_WIDTH = 4;
   localparam int FQ_DEPTH        = 16;

   // One queued instruction: its PC, the raw word and the NLP taken tag.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        taken;
   } fq_entry_t;

   // PC of lane `lane` in a fetch group starting at `base` (plain 32-bit wrap).
   function automatic logic [31:0] fq_lane_pc(input logic [31:0] base,
                                              input int unsigned lane);
      return base + 32'(lane << 2);
   endfunction

endpackage

// File: rtl/fq_rotate_mux.sv
// Modulo-indexed selector: output lane j takes data[(base + j) mod DEPTH].
// Used on the read side to present entries from head, and on the write side
// (with LANES = DEPTH, base = -tail) to scatter incoming lanes onto slots.
module fq_rotate_mux
   import frontend_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int LANES = FQ_DECODE_WIDTH
) (
   input  logic [$clog2(DEPTH)-1:0] base,
   input  fq_entry_t                data [DEPTH],
   output fq_entry_t                sel  [LANES]
);

   localparam int AW = $clog2(DEPTH);

   // Each output lane indexes the array at base+j; AW-bit addition wraps for free.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         sel[j] = data[AW'(base + AW'(j))];
      end
   end

endmodule

// File: rtl/fetch_instr_queue.sv
// Circular instruction queue between the icache response and decoder_stage.
// Accepts up to FETCH_WIDTH instructions per cycle, presents up to
// DECODE_WIDTH from the head, supports partial dequeue and one-cycle flush.
// Occupancy lives in its own register so head==tail is never ambiguous.
module fetch_instr_queue
   import frontend_pkg::*;
#(
   parameter int FETCH_WIDTH  = FQ_FETCH_WIDTH,
   parameter int DECODE_WIDTH = FQ_DECODE_WIDTH,
   parameter int DEPTH        = FQ_DEPTH
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              in_valid,
   input  logic [$clog2(FETCH_WIDTH)-1:0]    in_num,
   input  logic [31:0]                       in_pc,
   input  logic [FETCH_WIDTH*32-1:0]         in_instr,
   input  logic                              in_taken,
   output logic                              in_ready,
   output logic [DECODE_WIDTH-1:0]           out_valid,
   output logic [DECODE_WIDTH*32-1:0]        out_pc,
   output logic [DECODE_WIDTH*32-1:0]        out_instr,
   output logic [DECODE_WIDTH-1:0]           out_taken,
   input  logic [$clog2(DECODE_WIDTH+1)-1:0] deq_num,
   output logic [$clog2(DEPTH+1)-1:0]        count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int NW = $clog2(FETCH_WIDTH);

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count_r;

   // Storage is data only: never reset, never cleared by flush.
   fq_entry_t     mem      [DEPTH];

   // Incoming group padded out to DEPTH lanes so it can be rotated onto slots.
   fq_entry_t     lane_ent [DEPTH];
   fq_entry_t     slot_ent [DEPTH];
   fq_entry_t     rd_ent   [DECODE_WIDTH];

   logic          enq;
   logic [CW-1:0] enq_n;
   logic [AW-1:0] wr_base;
   logic [DEPTH-1:0] slot_we;

   // Ready looks only at registered occupancy; a same-cycle dequeue never
   // raises it, which keeps the write slots disjoint from the live entries.
   assign in_ready = (count_r <= CW'(DEPTH - FETCH_WIDTH));
   assign enq      = in_valid && in_ready && !flush;
   assign enq_n    = CW'(in_num) + CW'(1);
   assign count    = count_r;

   // Slot s receives lane (s - tail) mod DEPTH, i.e. rotate by -tail.
   assign wr_base  = AW'(0) - tail;

   // Expand the fetch group into per-lane entries; taken marks the last lane only.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         lane_ent[k] = '0;
      end
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         lane_ent[k].pc    = fq_lane_pc(in_pc, k);
         lane_ent[k].instr = in_instr[k*32 +: 32];
         lane_ent[k].taken = in_taken && (in_num == NW'(k));
      end
   end

   fq_rotate_mux #(
      .DEPTH (DEPTH),
      .LANES (DEPTH)
   ) u_wr_scatter (
      .base (wr_base),
      .data (lane_ent),
      .sel  (slot_ent)
   );

   // A slot is written when its lane offset from tail falls inside the group;
   // this handles a group straddling DEPTH-1 -> 0 in the same cycle.
   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         slot_we[s] = enq && (CW'(AW'(AW'(s) - tail)) < enq_n);
      end
   end

   // Storage write: only the slots claimed by the accepted group change.
   always_ff @(posedge clk) begin
      for (int s = 0; s < DEPTH; s++) begin
         if (slot_we[s]) begin
            mem[s] <= slot_ent[s];
         end
      end
   end

   fq_rotate_mux #(
      .DEPTH (DEPTH),
      .LANES (DECODE_WIDTH)
   ) u_rd_rotate (
      .base (head),
      .data (mem),
      .sel  (rd_ent)
   );

   // Present lanes from head; validity is a contiguous low mask from count.
   always_comb begin
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         out_valid[j]           = (CW'(j) < count_r);
         out_pc[j*32 +: 32]     = rd_ent[j].pc;
         out_instr[j*32 +: 32]  = rd_ent[j].instr;
         out_taken[j]           = rd_ent[j].taken;
      end
   end

   // Pointer and occupancy update; flush wins over both enqueue and dequeue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head    <= '0;
         tail    <= '0;
         count_r <= '0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count_r <= '0;
      end else begin
         head    <= head + AW'(deq_num);
         tail    <= tail + (enq ? AW'(enq_n) : AW'(0));
         count_r <= count_r + (enq ? enq_n : CW'(0)) - CW'(deq_num);
      end
   end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed bench for fetch_instr_queue at default geometry (4/4/16).
module tb_fetch_instr_queue;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic [1:0]    in_num;
   logic [31:0]   in_pc;
   logic [127:0]  in_instr;
   logic          in_taken;
   logic          in_ready;
   logic [3:0]    out_valid;
   logic [127:0]  out_pc;
   logic [127:0]  out_instr;
   logic [3:0]    out_taken;
   logic [2:0]    deq_num;
   logic [4:0]    count;

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] INSTR_A = 128'h00300193_00200113_00100093_00000013;
   localparam logic [127:0] INSTR_W = 128'hDEAD0003_BEEF0002_CAFE0001_F00D0000;

   fetch_instr_queue #(
      .FETCH_WIDTH  (4),
      .DECODE_WIDTH (4),
      .DEPTH        (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_num    (in_num),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_taken  (in_taken),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_taken (out_taken),
      .deq_num   (deq_num),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench timed out");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; dequeue legality checked first.
   task automatic step();
      checks++;
      assert (32'(deq_num) <= $countones(out_valid)) else begin
         failures++;
         $error("FAIL deq_legal observed=%0d expected<=%0d", deq_num, $countones(out_valid));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_enq(input logic [31:0] pc, input logic [1:0] num,
                            input logic taken, input logic [127:0] instr);
      in_valid = 1'b1;
      in_pc    = pc;
      in_num   = num;
      in_taken = taken;
      in_instr = instr;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_taken = 1'b0;
      flush    = 1'b0;
      deq_num  = 3'd0;
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_num   = 2'd0;
      in_pc    = 32'h0;
      in_instr = 128'h0;
      in_taken = 1'b0;
      deq_num  = 3'd0;

      // reset state
      #12;
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_count",     count,     5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic enqueue, one-cycle latency
      drive_enq(32'h1C000000, 2'd3, 1'b0, INSTR_A);
      chk("basic_same_cycle_empty", out_valid, 4'b0000);
      step();
      idle();
      chk("basic_out_valid", out_valid, 4'b1111);
      chk("basic_out_pc",    out_pc, {32'h1C00000C, 32'h1C000008, 32'h1C000004, 32'h1C000000});
      chk("basic_out_instr", out_instr, INSTR_A);
      chk("basic_out_taken", out_taken, 4'b0000);
      chk("basic_count",     count, 5'd4);
      step();
      chk("hold_count",  count, 5'd4);
      chk("hold_out_pc", out_pc, {32'h1C00000C, 32'h1C000008, 32'h1C000004, 32'h1C000000});

      // partial consume
      deq_num = 3'd1;
      step();
      chk("part1_count",     count, 5'd3);
      chk("part1_out_valid", out_valid, 4'b0111);
      step();
      idle();
      chk("part2_count",     count, 5'd2);
      chk("part2_out_valid", out_valid, 4'b0011);
      chk("part2_out_pc",    out_pc[63:0], {32'h1C00000C, 32'h1C000008});
      deq_num = 3'd2;
      step();
      idle();
      chk("part_drain_valid", out_valid, 4'b0000);

      // fill to 13 and back-pressure
      drive_enq(32'h00001000, 2'd3, 1'b0, 128'h0);
      step();
      drive_enq(32'h00002000, 2'd3, 1'b0, 128'h0);
      step();
      drive_enq(32'h00003000, 2'd3, 1'b0, 128'h0);
      step();
      chk("fill12_count",    count, 5'd12);
      chk("fill12_in_ready", in_ready, 1'b1);
      drive_enq(32'h00004000, 2'd0, 1'b0, 128'h0);
      step();
      chk("fill13_count",    count, 5'd13);
      chk("fill13_in_ready", in_ready, 1'b0);
      drive_enq(32'h00005555, 2'd3, 1'b0, 128'h0);
      deq_num = 3'd1;
      chk("bp_same_cycle_ready", in_ready, 1'b0);
      step();
      idle();
      chk("bp_next_count",    count, 5'd12);
      chk("bp_next_in_ready", in_ready, 1'b1);
      chk("bp_next_lane0",    out_pc[31:0], 32'h00001004);
      deq_num = 3'd4;
      step();
      chk("drain_a_lane0", out_pc[31:0], 32'h00002004);
      step();
      chk("drain_b_out_pc", out_pc, {32'h00004000, 32'h0000300C, 32'h00003008, 32'h00003004});
      step();
      idle();
      chk("drain_c_count", count, 5'd0);

      // sustained enqueue and dequeue in the same cycle
      drive_enq(32'h00005000, 2'd3, 1'b0, 128'h0);
      step();
      chk("stream1_count", count, 5'd4);
      drive_enq(32'h00006000, 2'd3, 1'b0, 128'h0);
      deq_num = 3'd4;
      step();
      chk("stream2_count", count, 5'd4);
      chk("stream2_lane0", out_pc[31:0], 32'h00006000);
      drive_enq(32'h00007000, 2'd3, 1'b0, 128'h0);
      step();
      chk("stream3_lane0", out_pc[31:0], 32'h00007000);
      drive_enq(32'h00008000, 2'd0, 1'b0, 128'h0);
      step();
      chk("stream4_count", count, 5'd1);
      chk("stream4_valid", out_valid, 4'b0001);
      chk("stream4_lane0", out_pc[31:0], 32'h00008000);
      idle();
      deq_num = 3'd1;
      step();
      idle();
      chk("stream_empty", count, 5'd0);

      // wrap: head = tail = 14, group lands on slots 14,15,0,1
      drive_enq(32'h00009000, 2'd3, 1'b0, INSTR_W);
      step();
      idle();
      chk("wrap_valid",    out_valid, 4'b1111);
      chk("wrap_out_pc",   out_pc, {32'h0000900C, 32'h00009008, 32'h00009004, 32'h00009000});
      chk("wrap_out_instr", out_instr, INSTR_W);
      drive_enq(32'h0000A000, 2'd0, 1'b0, 128'h0);
      deq_num = 3'd4;
      step();
      idle();
      chk("wrap_tail_count", count, 5'd1);
      chk("wrap_tail_lane0", out_pc[31:0], 32'h0000A000);
      deq_num = 3'd1;
      step();
      idle();

      // flush priority over enqueue and dequeue
      drive_enq(32'h0000B000, 2'd3, 1'b0, 128'h0);
      step();
      chk("pre_flush_count", count, 5'd4);
      drive_enq(32'h0000C000, 2'd3, 1'b0, 128'h0);
      deq_num = 3'd2;
      flush   = 1'b1;
      step();
      idle();
      chk("flush_count",    count, 5'd0);
      chk("flush_valid",    out_valid, 4'b0000);
      chk("flush_in_ready", in_ready, 1'b1);
      step();
      chk("flush_stays_empty", out_valid, 4'b0000);
      drive_enq(32'h0000D000, 2'd0, 1'b0, 128'h0);
      step();
      idle();
      chk("post_flush_count", count, 5'd1);
      chk("post_flush_lane0", out_pc[31:0], 32'h0000D000);
      deq_num = 3'd1;
      step();
      idle();

      // taken tag on the last valid lane only
      drive_enq(32'h0000E000, 2'd1, 1'b1, 128'h0);
      step();
      idle();
      chk("taken_valid", out_valid, 4'b0011);
      chk("taken_tag",   out_taken[1:0], 2'b10);
      chk("taken_pc",    out_pc[63:0], {32'h0000E004, 32'h0000E000});

      // asynchronous reset mid-stream
      drive_enq(32'h0000F000, 2'd3, 1'b0, 128'h0);
      step();
      idle();
      chk("pre_rst_count", count, 5'd6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid",    out_valid, 4'b0000);
      chk("async_rst_count",    count, 5'd0);
      chk("async_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("after_rst_count", count, 5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
